// File: rtl/uart_rx_deserializer_if.sv
// Pin bundle between the serial line / RX configuration and the UART RX deserializer.
// The master side drives the line and configuration; the slave side is the deserializer.
interface uart_rx_deserializer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
);
    logic                  RX_IN;
    logic [PRESC_W-1:0]    Prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  par_err;
    logic                  stp_err;

    modport master (
        output RX_IN, Prescale, PAR_EN, PAR_TYP,
        input  P_DATA, Data_Valid, par_err, stp_err
    );

    modport slave (
        input  RX_IN, Prescale, PAR_EN, PAR_TYP,
        output P_DATA, Data_Valid, par_err, stp_err
    );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive deserializer: start detect, 3-sample majority per bit, LSB-first byte
// assembly and stop check. Optional parity checking is built in with `UART_RX_PARITY_EN.
module uart_rx_deserializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    uart_rx_deserializer_if.slave rx
);
    localparam int BCNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_e;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

`ifdef UART_RX_PARITY_EN
    function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction
`endif

    state_e                state_q, state_d;
    logic [PRESC_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic [PRESC_W-1:0]    presc_q, presc_d;
    logic [BCNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [2:0]            samp_q, samp_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  data_valid_q, data_valid_d;
    logic                  stp_err_q, stp_err_d;

    logic [PRESC_W-1:0]    half_s;
    logic                  bit_end_s;
    logic                  bit_val_s;
    logic                  start_s;
    logic                  frame_ok_s;

`ifdef UART_RX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_typ_q, par_typ_d;
    logic par_bad_q, par_bad_d;
    logic par_err_q, par_err_d;
`else
    logic unused_par_s;
`endif

    assign half_s    = presc_q >> 1;
    assign bit_end_s = (state_q != S_IDLE) && (edge_cnt_q == (presc_q - PRESC_W'(1)));
    assign bit_val_s = majority3(samp_q);
    assign start_s   = (state_q == S_IDLE) && !rx.RX_IN;

`ifdef UART_RX_PARITY_EN
    assign frame_ok_s = !par_bad_q;
    assign rx.par_err = par_err_q;
`else
    assign frame_ok_s   = 1'b1;
    assign rx.par_err   = 1'b0;
    assign unused_par_s = rx.PAR_EN ^ rx.PAR_TYP;
`endif

    assign rx.P_DATA     = p_data_q;
    assign rx.Data_Valid = data_valid_q;
    assign rx.stp_err    = stp_err_q;

    // FSM state register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: every non-idle state advances only at its bit end
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start_s) state_d = S_START;
                else         state_d = S_IDLE;
            end
            S_START: begin
                if (bit_end_s) state_d = bit_val_s ? S_IDLE : S_DATA;
                else           state_d = S_START;
            end
            S_DATA: begin
                if (bit_end_s && (bit_cnt_q == BIT_LAST)) begin
`ifdef UART_RX_PARITY_EN
                    if (par_en_q) state_d = S_PARITY;
                    else          state_d = S_STOP;
`else
                    state_d = S_STOP;
`endif
                end else begin
                    state_d = S_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_end_s) state_d = S_STOP;
                else           state_d = S_PARITY;
            end
`endif
            S_STOP: begin
                if (bit_end_s) state_d = S_IDLE;
                else           state_d = S_STOP;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs and datapath: counters, sampling, shifting and result strobes
    always_comb begin
        edge_cnt_d   = edge_cnt_q;
        presc_d      = presc_q;
        bit_cnt_d    = bit_cnt_q;
        samp_d       = samp_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        stp_err_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        par_bad_d = par_bad_q;
        par_err_d = 1'b0;
`endif

        if (state_q == S_IDLE) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
            if (start_s) begin
                presc_d = rx.Prescale;
`ifdef UART_RX_PARITY_EN
                par_en_d  = rx.PAR_EN;
                par_typ_d = rx.PAR_TYP;
`endif
            end else begin
                presc_d = presc_q;
            end
        end else begin
            if (bit_end_s) edge_cnt_d = '0;
            else           edge_cnt_d = edge_cnt_q + PRESC_W'(1);

            // three samples straddle the bit centre; decided later at bit end
            if (edge_cnt_q == (half_s - PRESC_W'(2)))      samp_d[0] = rx.RX_IN;
            else if (edge_cnt_q == (half_s - PRESC_W'(1))) samp_d[1] = rx.RX_IN;
            else if (edge_cnt_q == half_s)                 samp_d[2] = rx.RX_IN;
            else                                           samp_d    = samp_q;
        end

        case (state_q)
            S_DATA: begin
                if (bit_end_s) begin
                    shift_d = {bit_val_s, shift_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == BIT_LAST) bit_cnt_d = '0;
                    else                       bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                end else begin
                    shift_d = shift_q;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (bit_end_s && (bit_val_s != expected_parity(shift_q, par_typ_q))) begin
                    par_err_d = 1'b1;
                    par_bad_d = 1'b1;
                end else begin
                    par_err_d = 1'b0;
                end
            end
`endif
            S_STOP: begin
                if (bit_end_s) begin
                    if (!bit_val_s) begin
                        stp_err_d = 1'b1;
                    end else if (frame_ok_s) begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end else begin
                        data_valid_d = 1'b0;
                    end
                end else begin
                    stp_err_d = 1'b0;
                end
            end
            default: begin
                shift_d = shift_q;
            end
        endcase
    end

    // Datapath and registered output flops
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            edge_cnt_q   <= '0;
            presc_q      <= '0;
            bit_cnt_q    <= '0;
            samp_q       <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            stp_err_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_bad_q <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            edge_cnt_q   <= edge_cnt_d;
            presc_q      <= presc_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_q       <= samp_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            stp_err_q    <= stp_err_d;
`ifdef UART_RX_PARITY_EN
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            par_bad_q <= par_bad_d;
            par_err_q <= par_err_d;
`endif
        end
    end
endmodule
